// File: rtl/bus_host_arb_if.sv
// Host-side and downstream signal bundle for bus_host_arb.
// The slave modport is the arbiter's view; master is the view of whatever
// drives the hosts and models the downstream device.
interface bus_host_arb_if #(
  parameter int NrHosts      = 2,
  parameter int DataWidth    = 32,
  parameter int AddressWidth = 32
);
  logic [NrHosts-1:0]              host_req_i;
  logic [NrHosts-1:0]              host_gnt_o;
  logic [NrHosts*AddressWidth-1:0] host_addr_i;
  logic [NrHosts-1:0]              host_we_i;
  logic [NrHosts*4-1:0]            host_be_i;
  logic [NrHosts*DataWidth-1:0]    host_wdata_i;
  logic [NrHosts-1:0]              host_rvalid_o;
  logic [DataWidth-1:0]            host_rdata_o;
  logic [NrHosts-1:0]              host_err_o;

  logic                            out_req_o;
  logic                            out_gnt_i;
  logic [AddressWidth-1:0]         out_addr_o;
  logic                            out_we_o;
  logic [3:0]                      out_be_o;
  logic [DataWidth-1:0]            out_wdata_o;
  logic                            out_rvalid_i;
  logic [DataWidth-1:0]            out_rdata_i;
  logic                            out_err_i;

  modport slave (
    input  host_req_i, host_addr_i, host_we_i, host_be_i, host_wdata_i,
    input  out_gnt_i, out_rvalid_i, out_rdata_i, out_err_i,
    output host_gnt_o, host_rvalid_o, host_rdata_o, host_err_o,
    output out_req_o, out_addr_o, out_we_o, out_be_o, out_wdata_o
  );

  modport master (
    output host_req_i, host_addr_i, host_we_i, host_be_i, host_wdata_i,
    output out_gnt_i, out_rvalid_i, out_rdata_i, out_err_i,
    input  host_gnt_o, host_rvalid_o, host_rdata_o, host_err_o,
    input  out_req_o, out_addr_o, out_we_o, out_be_o, out_wdata_o
  );
endinterface

// File: rtl/bus_host_arb.sv
// Round-robin arbiter sharing one req/gnt/rvalid downstream port between
// NrHosts requesters, with a single outstanding transaction.
// Optional feature macro: ARB_TIMEOUT_EN -- when defined, a response that
// does not arrive within TimeoutCycles RESP cycles is answered locally with
// an error; when undefined, RESP waits indefinitely.
module bus_host_arb #(
  parameter int NrHosts       = 2,
  parameter int DataWidth     = 32,
  parameter int AddressWidth  = 32,
  parameter int TimeoutCycles = 255
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  bus_host_arb_if.slave  bus
);

  localparam int IdxW = (NrHosts > 1) ? $clog2(NrHosts) : 1;

  typedef logic [IdxW-1:0] idx_t;
  typedef enum logic [1:0] {IDLE, ADDR, RESP} state_e;

  state_e state_q, state_d;
  idx_t   rr_ptr_q, rr_ptr_d;
  idx_t   owner_q, owner_d;

  // Per-host views of the packed request fields
  logic [AddressWidth-1:0] addr_arr  [NrHosts];
  logic [3:0]              be_arr    [NrHosts];
  logic [DataWidth-1:0]    wdata_arr [NrHosts];

  // Combinational arbitration and datapath select
  logic                  win_vld;
  idx_t                  win_idx;
  idx_t                  sel_idx;
  logic                  req_int;
  logic [NrHosts-1:0]    gnt_int;
  logic [NrHosts-1:0]    rvalid_int;
  logic [NrHosts-1:0]    err_int;
  logic [DataWidth-1:0]  rdata_int;

`ifdef ARB_TIMEOUT_EN
  logic [15:0] wait_cnt_q, wait_cnt_d;
`else
  logic [15:0] unused_timeout;
  assign unused_timeout = 16'(TimeoutCycles);
`endif

  // Index of the host after i, wrapping NrHosts-1 back to 0
  function automatic idx_t wrap_inc(idx_t i);
    logic [IdxW:0] s;
    s = {1'b0, i} + (IdxW+1)'(1);
    if (s >= (IdxW+1)'(NrHosts)) s = '0;
    return s[IdxW-1:0];
  endfunction

  // Split the packed host buses into per-host slices
  always_comb begin
    for (int i = 0; i < NrHosts; i++) begin
      addr_arr[i]  = bus.host_addr_i[i*AddressWidth +: AddressWidth];
      be_arr[i]    = bus.host_be_i[i*4 +: 4];
      wdata_arr[i] = bus.host_wdata_i[i*DataWidth +: DataWidth];
    end
  end

  // Winner = first requester found scanning upward from rr_ptr, modulo NrHosts;
  // scanning offsets high-to-low lets the smallest offset overwrite last
  always_comb begin
    logic [IdxW:0] cand;
    win_vld = |bus.host_req_i;
    win_idx = '0;
    cand    = '0;
    for (int k = NrHosts-1; k >= 0; k--) begin
      cand = {1'b0, rr_ptr_q} + (IdxW+1)'(k);
      if (cand >= (IdxW+1)'(NrHosts)) cand = cand - (IdxW+1)'(NrHosts);
      if (bus.host_req_i[cand[IdxW-1:0]]) win_idx = cand[IdxW-1:0];
    end
  end

  // FSM next-state and host/downstream handshake outputs
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    sel_idx    = owner_q;
    req_int    = 1'b0;
    gnt_int    = '0;
    rvalid_int = '0;
    err_int    = '0;
    rdata_int  = bus.out_rdata_i;
`ifdef ARB_TIMEOUT_EN
    wait_cnt_d = wait_cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (win_vld) begin
          sel_idx = win_idx;
          req_int = 1'b1;
          owner_d = win_idx;
          if (bus.out_gnt_i) begin
            gnt_int[win_idx] = 1'b1;
            rr_ptr_d         = wrap_inc(win_idx);
            state_d          = RESP;
`ifdef ARB_TIMEOUT_EN
            wait_cnt_d       = '0;
`endif
          end else begin
            state_d = ADDR;
          end
        end
      end
      ADDR: begin
        // Owner withdrawing its request early abandons the transaction
        // without advancing the round-robin pointer
        if (bus.host_req_i[owner_q]) begin
          req_int = 1'b1;
          if (bus.out_gnt_i) begin
            gnt_int[owner_q] = 1'b1;
            rr_ptr_d         = wrap_inc(owner_q);
            state_d          = RESP;
`ifdef ARB_TIMEOUT_EN
            wait_cnt_d       = '0;
`endif
          end
        end else begin
          state_d = IDLE;
        end
      end
      RESP: begin
        // A real response takes priority over a timeout in the same cycle
        if (bus.out_rvalid_i) begin
          rvalid_int[owner_q] = 1'b1;
          err_int[owner_q]    = bus.out_err_i;
          state_d             = IDLE;
        end
`ifdef ARB_TIMEOUT_EN
        else if (wait_cnt_q == 16'(TimeoutCycles - 1)) begin
          rvalid_int[owner_q] = 1'b1;
          err_int[owner_q]    = 1'b1;
          rdata_int           = '0;
          state_d             = IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs forced to zero while reset is asserted; request fields only
  // reflect a host while out_req_o is high
  assign bus.out_req_o     = rst_ni & req_int;
  assign bus.out_addr_o    = bus.out_req_o ? addr_arr[sel_idx]       : '0;
  assign bus.out_we_o      = bus.out_req_o & bus.host_we_i[sel_idx];
  assign bus.out_be_o      = bus.out_req_o ? be_arr[sel_idx]         : '0;
  assign bus.out_wdata_o   = bus.out_req_o ? wdata_arr[sel_idx]      : '0;
  assign bus.host_gnt_o    = rst_ni ? gnt_int    : '0;
  assign bus.host_rvalid_o = rst_ni ? rvalid_int : '0;
  assign bus.host_err_o    = rst_ni ? err_int    : '0;
  assign bus.host_rdata_o  = rst_ni ? rdata_int  : '0;

  // State, round-robin pointer and owner registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  // Response wait counter
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) wait_cnt_q <= '0;
    else         wait_cnt_q <= wait_cnt_d;
  end
`endif

endmodule

// File: tb/tb_bus_host_arb.sv
// Self-checking bench for bus_host_arb: directed scenarios plus a randomized
// run compared against a transaction-level reference model.
module tb_bus_host_arb;
  localparam int NH = 2;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  bus_host_arb_if #(.NrHosts(NH), .DataWidth(DW), .AddressWidth(AW)) bus ();

  bus_host_arb #(
    .NrHosts(NH), .DataWidth(DW), .AddressWidth(AW), .TimeoutCycles(TO)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  task automatic clear_inputs();
    bus.host_req_i   = '0;
    bus.host_addr_i  = '0;
    bus.host_we_i    = '0;
    bus.host_be_i    = '0;
    bus.host_wdata_i = '0;
    bus.out_gnt_i    = 1'b0;
    bus.out_rvalid_i = 1'b0;
    bus.out_rdata_i  = '0;
    bus.out_err_i    = 1'b0;
  endtask

  task automatic set_host(input int h, input logic [AW-1:0] a, input logic we,
                          input logic [3:0] be, input logic [DW-1:0] d);
    bus.host_addr_i[h*AW +: AW]  = a;
    bus.host_we_i[h]             = we;
    bus.host_be_i[h*4 +: 4]      = be;
    bus.host_wdata_i[h*DW +: DW] = d;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    bus.host_req_i  = 2'b11;
    set_host(0, 32'h1111_0000, 1'b1, 4'hF, 32'hAAAA_AAAA);
    set_host(1, 32'h2222_0000, 1'b1, 4'hF, 32'h5555_5555);
    bus.out_gnt_i    = 1'b1;
    bus.out_rvalid_i = 1'b1;
    bus.out_err_i    = 1'b1;
    bus.out_rdata_i  = 32'hFFFF_FFFF;
    @(negedge clk); #2;
    checks++; if (bus.out_req_o !== 1'b0) begin errors++; $display("FAIL reset_out_req got %b exp 0", bus.out_req_o); end
    checks++; if (bus.host_gnt_o !== 2'b00) begin errors++; $display("FAIL reset_gnt got %b exp 00", bus.host_gnt_o); end
    checks++; if ({bus.host_rvalid_o, bus.host_err_o} !== 4'b0) begin errors++; $display("FAIL reset_rvalid_err got %b exp 0000", {bus.host_rvalid_o, bus.host_err_o}); end
    checks++; if (bus.host_rdata_o !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", bus.host_rdata_o); end
    checks++; if ({bus.out_addr_o, bus.out_we_o, bus.out_be_o, bus.out_wdata_o} !== '0) begin errors++; $display("FAIL reset_fields got %h/%b/%h/%h exp 0", bus.out_addr_o, bus.out_we_o, bus.out_be_o, bus.out_wdata_o); end
    do_reset();
  endtask

  task automatic test_single_read();
    do_reset();
    @(negedge clk);
    bus.host_req_i = 2'b01;
    set_host(0, 32'h0010_0004, 1'b0, 4'hF, 32'h0);
    set_host(1, 32'h0020_0008, 1'b0, 4'hF, 32'h0);
    bus.out_gnt_i = 1'b1;
    #2;
    checks++; if (bus.host_gnt_o !== 2'b01) begin errors++; $display("FAIL read_gnt got %b exp 01", bus.host_gnt_o); end
    checks++; if (bus.out_req_o !== 1'b1 || bus.out_addr_o !== 32'h0010_0004) begin errors++; $display("FAIL read_addr got req=%b %h exp 1 00100004", bus.out_req_o, bus.out_addr_o); end
    @(negedge clk);
    bus.host_req_i   = 2'b00;
    bus.out_gnt_i    = 1'b0;
    bus.out_rvalid_i = 1'b1;
    bus.out_rdata_i  = 32'hDEAD_BEEF;
    #2;
    checks++; if (bus.host_rvalid_o !== 2'b01) begin errors++; $display("FAIL read_rvalid got %b exp 01", bus.host_rvalid_o); end
    checks++; if (bus.host_rdata_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL read_rdata got %h exp deadbeef", bus.host_rdata_o); end
    checks++; if (bus.out_req_o !== 1'b0 || bus.host_gnt_o !== 2'b00) begin errors++; $display("FAIL read_resp_quiet got req=%b gnt=%b exp 0 00", bus.out_req_o, bus.host_gnt_o); end
    @(negedge clk);
    bus.out_rvalid_i = 1'b0;
    bus.host_req_i   = 2'b11;
    #2;
    checks++; if (bus.out_addr_o !== 32'h0020_0008) begin errors++; $display("FAIL read_rrptr got %h exp 00200008", bus.out_addr_o); end
  endtask

  task automatic test_back_to_back();
    logic [NH-1:0] eg, ev;
    do_reset();
    @(negedge clk);
    bus.host_req_i   = 2'b11;
    bus.out_gnt_i    = 1'b1;
    bus.out_rvalid_i = 1'b1;
    bus.out_rdata_i  = 32'h0BAD_F00D;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) @(negedge clk);
      #2;
      eg = (c % 4 == 0) ? 2'b01 : (c % 4 == 2) ? 2'b10 : 2'b00;
      ev = (c % 4 == 1) ? 2'b01 : (c % 4 == 3) ? 2'b10 : 2'b00;
      checks++; if (bus.host_gnt_o !== eg) begin errors++; $display("FAIL b2b_gnt c%0d got %b exp %b", c, bus.host_gnt_o, eg); end
      checks++; if (bus.host_rvalid_o !== ev) begin errors++; $display("FAIL b2b_rvalid c%0d got %b exp %b", c, bus.host_rvalid_o, ev); end
    end
  endtask

  task automatic test_addr_hold();
    do_reset();
    @(negedge clk);
    set_host(0, 32'hA000_0000, 1'b0, 4'hF, 32'h0);
    set_host(1, 32'hB000_0004, 1'b0, 4'hF, 32'h0);
    bus.host_req_i = 2'b10;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 1) bus.host_req_i = 2'b11;
      #2;
      checks++; if (bus.out_addr_o !== 32'hB000_0004 || bus.host_gnt_o !== 2'b00) begin errors++; $display("FAIL hold_wait c%0d got %h gnt=%b exp b0000004 00", c, bus.out_addr_o, bus.host_gnt_o); end
    end
    @(negedge clk);
    bus.out_gnt_i = 1'b1;
    #2;
    checks++; if (bus.host_gnt_o !== 2'b10 || bus.out_addr_o !== 32'hB000_0004) begin errors++; $display("FAIL hold_gnt got gnt=%b %h exp 10 b0000004", bus.host_gnt_o, bus.out_addr_o); end
    @(negedge clk);
    bus.host_req_i   = 2'b01;
    bus.out_gnt_i    = 1'b0;
    bus.out_rvalid_i = 1'b1;
    #2;
    checks++; if (bus.host_rvalid_o !== 2'b10) begin errors++; $display("FAIL hold_rvalid got %b exp 10", bus.host_rvalid_o); end
    @(negedge clk);
    bus.out_rvalid_i = 1'b0;
    bus.out_gnt_i    = 1'b1;
    #2;
    checks++; if (bus.host_gnt_o !== 2'b01 || bus.out_addr_o !== 32'hA000_0000) begin errors++; $display("FAIL hold_next got gnt=%b %h exp 01 a0000000", bus.host_gnt_o, bus.out_addr_o); end
  endtask

  task automatic test_write_err();
    do_reset();
    @(negedge clk);
    set_host(0, 32'h0000_0100, 1'b0, 4'hF, 32'hCAFE_CAFE);
    set_host(1, 32'h0000_0200, 1'b1, 4'b0011, 32'h1234_5678);
    bus.host_req_i = 2'b10;
    bus.out_gnt_i  = 1'b1;
    #2;
    checks++; if ({bus.out_we_o, bus.out_be_o, bus.out_wdata_o} !== {1'b1, 4'b0011, 32'h1234_5678}) begin errors++; $display("FAIL wr_fields got we=%b be=%b %h exp 1 0011 12345678", bus.out_we_o, bus.out_be_o, bus.out_wdata_o); end
    checks++; if (bus.host_gnt_o !== 2'b10) begin errors++; $display("FAIL wr_gnt got %b exp 10", bus.host_gnt_o); end
    @(negedge clk);
    bus.host_req_i   = 2'b00;
    bus.out_gnt_i    = 1'b0;
    bus.out_rvalid_i = 1'b1;
    bus.out_err_i    = 1'b1;
    #2;
    checks++; if (bus.host_rvalid_o !== 2'b10 || bus.host_err_o !== 2'b10) begin errors++; $display("FAIL wr_err got rvalid=%b err=%b exp 10 10", bus.host_rvalid_o, bus.host_err_o); end
    @(negedge clk);
    bus.out_rvalid_i = 1'b0;
    bus.out_err_i    = 1'b0;
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    @(negedge clk);
    set_host(0, 32'h0000_0040, 1'b0, 4'hF, 32'h0);
    bus.host_req_i  = 2'b01;
    bus.out_gnt_i   = 1'b1;
    bus.out_rdata_i = 32'hFFFF_FFFF;
    #2;
    checks++; if (bus.host_gnt_o !== 2'b01) begin errors++; $display("FAIL to_gnt got %b exp 01", bus.host_gnt_o); end
    @(negedge clk);
    bus.host_req_i = 2'b00;
    bus.out_gnt_i  = 1'b0;
    for (int c = 1; c <= TO; c++) begin
      if (c > 1) @(negedge clk);
      #2;
      if (c < TO) begin
        checks++; if (bus.host_rvalid_o !== 2'b00) begin errors++; $display("FAIL to_early c%0d got %b exp 00", c, bus.host_rvalid_o); end
      end else begin
        checks++; if (bus.host_rvalid_o !== 2'b01 || bus.host_err_o !== 2'b01) begin errors++; $display("FAIL to_fire got rvalid=%b err=%b exp 01 01", bus.host_rvalid_o, bus.host_err_o); end
        checks++; if (bus.host_rdata_o !== 32'h0) begin errors++; $display("FAIL to_rdata got %h exp 0", bus.host_rdata_o); end
      end
    end
    @(negedge clk);
    bus.out_rvalid_i = 1'b1;
    #2;
    checks++; if (bus.host_rvalid_o !== 2'b00) begin errors++; $display("FAIL to_stray got %b exp 00", bus.host_rvalid_o); end
    @(negedge clk);
    bus.out_rvalid_i = 1'b0;
  endtask
`else
  task automatic test_resp_wait();
    do_reset();
    @(negedge clk);
    bus.host_req_i = 2'b01;
    bus.out_gnt_i  = 1'b1;
    #2;
    checks++; if (bus.host_gnt_o !== 2'b01) begin errors++; $display("FAIL wait_gnt got %b exp 01", bus.host_gnt_o); end
    @(negedge clk);
    bus.host_req_i = 2'b00;
    bus.out_gnt_i  = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (c > 0) @(negedge clk);
      #2;
      checks++; if (bus.host_rvalid_o !== 2'b00) begin errors++; $display("FAIL wait_idle c%0d got %b exp 00", c, bus.host_rvalid_o); end
    end
    @(negedge clk);
    bus.out_rvalid_i = 1'b1;
    #2;
    checks++; if (bus.host_rvalid_o !== 2'b01 || bus.host_err_o !== 2'b00) begin errors++; $display("FAIL wait_resp got rvalid=%b err=%b exp 01 00", bus.host_rvalid_o, bus.host_err_o); end
    @(negedge clk);
    bus.out_rvalid_i = 1'b0;
  endtask
`endif

  task automatic test_reset_mid();
    do_reset();
    @(negedge clk);
    set_host(0, 32'hC000_0000, 1'b0, 4'hF, 32'h0);
    set_host(1, 32'hD000_0000, 1'b0, 4'hF, 32'h0);
    bus.host_req_i = 2'b01;
    bus.out_gnt_i  = 1'b1;
    @(negedge clk);
    bus.host_req_i   = 2'b00;
    bus.out_gnt_i    = 1'b0;
    bus.out_rvalid_i = 1'b1;
    bus.out_rdata_i  = 32'h7777_7777;
    #2;
    checks++; if (bus.host_rvalid_o !== 2'b01) begin errors++; $display("FAIL mid_pre got %b exp 01", bus.host_rvalid_o); end
    rst_n = 1'b0;
    #1;
    checks++; if ({bus.host_rvalid_o, bus.host_err_o, bus.host_gnt_o, bus.out_req_o} !== '0 || bus.host_rdata_o !== 32'h0) begin errors++; $display("FAIL mid_async got rv=%b err=%b gnt=%b req=%b rdata=%h exp all 0", bus.host_rvalid_o, bus.host_err_o, bus.host_gnt_o, bus.out_req_o, bus.host_rdata_o); end
    @(negedge clk);
    rst_n            = 1'b1;
    bus.out_rvalid_i = 1'b0;
    bus.host_req_i   = 2'b11;
    #2;
    checks++; if (bus.out_req_o !== 1'b1 || bus.out_addr_o !== 32'hC000_0000) begin errors++; $display("FAIL mid_rr0 got req=%b %h exp 1 c0000000", bus.out_req_o, bus.out_addr_o); end
  endtask

  // Randomized traffic against a transaction-level model: phase 0 = no
  // transaction, 1 = winner chosen but not yet accepted, 2 = awaiting response
  task automatic test_random();
    int m_rr, m_owner, m_phase, m_wait, w, sel;
    logic [NH-1:0] rq, e_gnt, e_rv, e_err;
    logic          e_req;
    logic [DW-1:0] e_rdata;
    logic [AW+1+4+DW-1:0] e_fld, a_fld;
    do_reset();
    m_rr = 0; m_owner = 0; m_phase = 0; m_wait = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      for (int h = 0; h < NH; h++) begin
        if ($urandom_range(3) == 0) bus.host_req_i[h] = ~bus.host_req_i[h];
        set_host(h, $urandom(), 1'($urandom_range(1)), 4'($urandom_range(15)), $urandom());
      end
      bus.out_gnt_i    = 1'($urandom_range(1));
      bus.out_rvalid_i = ($urandom_range(2) == 0);
      bus.out_err_i    = 1'($urandom_range(1));
      bus.out_rdata_i  = $urandom();
      rq      = bus.host_req_i;
      e_gnt   = '0; e_rv = '0; e_err = '0; e_req = 1'b0;
      e_rdata = bus.out_rdata_i;
      sel     = -1;
      if (m_phase == 0) begin
        w = -1;
        for (int k = 0; k < NH; k++)
          if (w < 0 && rq[(m_rr + k) % NH]) w = (m_rr + k) % NH;
        if (w >= 0) begin
          sel = w; e_req = 1'b1; m_owner = w;
          if (bus.out_gnt_i) begin e_gnt[w] = 1'b1; m_rr = (w + 1) % NH; m_phase = 2; m_wait = 0; end
          else m_phase = 1;
        end
      end else if (m_phase == 1) begin
        if (rq[m_owner]) begin
          sel = m_owner; e_req = 1'b1;
          if (bus.out_gnt_i) begin e_gnt[m_owner] = 1'b1; m_rr = (m_owner + 1) % NH; m_phase = 2; m_wait = 0; end
        end else m_phase = 0;
      end else begin
        if (bus.out_rvalid_i) begin
          e_rv[m_owner] = 1'b1; e_err[m_owner] = bus.out_err_i; m_phase = 0;
        end
`ifdef ARB_TIMEOUT_EN
        else if (m_wait + 1 == TO) begin
          e_rv[m_owner] = 1'b1; e_err[m_owner] = 1'b1; e_rdata = '0; m_phase = 0;
        end else m_wait++;
`endif
      end
      e_fld = '0;
      if (sel >= 0)
        e_fld = {bus.host_addr_i[sel*AW +: AW], bus.host_we_i[sel], bus.host_be_i[sel*4 +: 4], bus.host_wdata_i[sel*DW +: DW]};
      #2;
      a_fld = {bus.out_addr_o, bus.out_we_o, bus.out_be_o, bus.out_wdata_o};
      checks++; if (bus.out_req_o !== e_req) begin errors++; $display("FAIL rnd_req c%0d got %b exp %b", c, bus.out_req_o, e_req); end
      checks++; if (a_fld !== e_fld) begin errors++; $display("FAIL rnd_fields c%0d got %h exp %h", c, a_fld, e_fld); end
      checks++; if (bus.host_gnt_o !== e_gnt) begin errors++; $display("FAIL rnd_gnt c%0d got %b exp %b", c, bus.host_gnt_o, e_gnt); end
      checks++; if (bus.host_rvalid_o !== e_rv) begin errors++; $display("FAIL rnd_rvalid c%0d got %b exp %b", c, bus.host_rvalid_o, e_rv); end
      checks++; if (bus.host_err_o !== e_err) begin errors++; $display("FAIL rnd_err c%0d got %b exp %b", c, bus.host_err_o, e_err); end
      checks++; if (bus.host_rdata_o !== e_rdata) begin errors++; $display("FAIL rnd_rdata c%0d got %h exp %h", c, bus.host_rdata_o, e_rdata); end
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_read();
    test_back_to_back();
    test_addr_hold();
    test_write_err();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`else
    test_resp_wait();
`endif
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
